// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   div_state_t       : controller states (IDLE, ITER, FIN, DONE)
//   DIV_WIDTH_DEFAULT : default operand width
//   cnt_width()       : width of the iteration counter for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // The counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/twos_complement_n.sv
// Combinational two's-complement negate.
//   a : WIDTH-bit input value
//   y : WIDTH-bit negated value (-a, modulo 2^WIDTH)
module twos_complement_n #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = (~a) + WIDTH'(1);

endmodule

// File: rtl/div_seq_n.sv
// Sequential restoring divider, one quotient bit per clock, signed or unsigned.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   ctrl_DIV           : start pulse; operands and ctrl_signed sampled with it
//   ctrl_signed        : 1 = two's-complement division, 0 = unsigned
//   data_operandA/B    : dividend / divisor
//   data_result        : quotient, truncated toward zero
//   data_remainder     : remainder, sign follows the dividend
//   data_exception     : divide-by-zero or signed overflow (MIN / -1)
//   data_resultRDY     : one-cycle pulse when a result is available
//   busy               : operation in progress (ITER or FIN)
// Results are held in output registers until the next completed operation.
module div_seq_n
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] b_mag;
  logic             neg_q;
  logic             neg_r;
  logic             exc_reg;

  // Operand magnitudes.
  logic [WIDTH-1:0] a_neg, b_neg, a_abs, b_abs;

  twos_complement_n #(.WIDTH(WIDTH)) u_neg_a (.a(data_operandA), .y(a_neg));
  twos_complement_n #(.WIDTH(WIDTH)) u_neg_b (.a(data_operandB), .y(b_neg));

  assign a_abs = (ctrl_signed && data_operandA[WIDTH-1]) ? a_neg : data_operandA;
  assign b_abs = (ctrl_signed && data_operandB[WIDTH-1]) ? b_neg : data_operandB;

  logic div_zero, sgn_ovf;
  assign div_zero = (data_operandB == '0);
  assign sgn_ovf  = ctrl_signed && (data_operandA == MIN_VAL) && (data_operandB == '1);

  // One restoring step. The trial subtraction is done modulo 2^WIDTH: when it
  // is accepted the true difference is below |B|, so it always fits.
  logic [WIDTH:0]   r_shift;
  logic             step_ok;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  assign r_shift = {r_reg, q_reg[WIDTH-1]};
  assign step_ok = (r_shift >= {1'b0, b_mag});
  assign r_step  = step_ok ? (r_shift[WIDTH-1:0] - b_mag) : r_shift[WIDTH-1:0];
  assign q_step  = {q_reg[WIDTH-2:0], step_ok};

  // Sign fix-up of the final quotient and remainder.
  logic [WIDTH-1:0] q_neg, r_neg;

  twos_complement_n #(.WIDTH(WIDTH)) u_neg_q (.a(q_reg), .y(q_neg));
  twos_complement_n #(.WIDTH(WIDTH)) u_neg_r (.a(r_reg), .y(r_neg));

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      r_reg          <= '0;
      q_reg          <= '0;
      b_mag          <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      exc_reg        <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      // A start in any state (re)launches an operation; an aborted one
      // never reaches DONE, so it produces no ready pulse.
      cnt   <= '0;
      b_mag <= b_abs;
      if (div_zero || sgn_ovf) begin
        // Early exits preload the final values with no sign fix-up and pass
        // through FIN, so all outputs are still registered on entry to DONE.
        q_reg   <= div_zero ? '1 : MIN_VAL;
        r_reg   <= div_zero ? data_operandA : '0;
        neg_q   <= 1'b0;
        neg_r   <= 1'b0;
        exc_reg <= 1'b1;
        state   <= FIN;
      end else begin
        q_reg   <= a_abs;
        r_reg   <= '0;
        neg_q   <= ctrl_signed & (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
        neg_r   <= ctrl_signed & data_operandA[WIDTH-1];
        exc_reg <= 1'b0;
        state   <= ITER;
      end
    end else begin
      case (state)
        ITER: begin
          r_reg <= r_step;
          q_reg <= q_step;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          data_result    <= neg_q ? q_neg : q_reg;
          data_remainder <= neg_r ? r_neg : r_reg;
          data_exception <= exc_reg;
          state          <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign data_resultRDY = (state == DONE);
  assign busy           = (state == ITER) || (state == FIN);

endmodule

// File: tb/tb_div_seq_n.sv
// Self-checking bench for div_seq_n: 32-bit directed vector table, restart and
// reset corner sequences, and an 8-bit instance with directed and random cases.
module tb_div_seq_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        div32, s32, e32, rdy32, busy32;
  logic [31:0] a32, b32, q32, r32;
  logic        div8, s8, e8, rdy8, busy8;
  logic [7:0]  a8, b8, q8, r8;

  div_seq_n #(.WIDTH(32)) dut32 (
    .clock(clk), .reset(rst), .ctrl_DIV(div32), .ctrl_signed(s32),
    .data_operandA(a32), .data_operandB(b32), .data_result(q32),
    .data_remainder(r32), .data_exception(e32), .data_resultRDY(rdy32),
    .busy(busy32)
  );

  div_seq_n #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst), .ctrl_DIV(div8), .ctrl_signed(s8),
    .data_operandA(a8), .data_operandB(b8), .data_result(q8),
    .data_remainder(r8), .data_exception(e8), .data_resultRDY(rdy8),
    .busy(busy8)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Latency = number of cycles after the start cycle at which ready is seen
  // (ready in the cycle after edge E_k gives k+1); 0 means it never came.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output int lat);
    @(negedge clk);
    a32 = a; b32 = b; s32 = sgn; div32 = 1'b1;
    @(posedge clk); #1;
    div32 = 1'b0;
    lat = 0;
    check("busy32 after start", {31'b0, busy32}, 32'd1);
    for (int k = 1; k <= 60; k++) begin
      if (rdy32) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                      output int lat);
    @(negedge clk);
    a8 = a; b8 = b; s8 = sgn; div8 = 1'b1;
    @(posedge clk); #1;
    div8 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      if (rdy8) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic void model8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                                 output logic [7:0] q, output logic [7:0] r,
                                 output logic e, output int lat);
    int sa, sb;
    if (b == 8'h00) begin
      q = 8'hFF; r = a; e = 1'b1; lat = 2;
    end else if (sgn && a == 8'h80 && b == 8'hFF) begin
      q = 8'h80; r = 8'h00; e = 1'b1; lat = 2;
    end else if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = 8'(sa / sb); r = 8'(sa % sb); e = 1'b0; lat = 10;
    end else begin
      q = a / b; r = a % b; e = 1'b0; lat = 10;
    end
  endfunction

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        exc;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pulses, elat;
    logic [7:0] ra, rb, eq, er;
    logic ee, rs;

    vecs[0]  = '{"s 100/7",          32'd100,       32'd7,         1'b1, 32'd14,        32'd2,         1'b0, 34};
    vecs[1]  = '{"s -100/7",         32'hFFFFFF9C,  32'd7,         1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 34};
    vecs[2]  = '{"s 100/-7",         32'd100,       32'hFFFFFFF9,  1'b1, 32'hFFFFFFF2,  32'd2,         1'b0, 34};
    vecs[3]  = '{"s -100/-7",        32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 32'd14,        32'hFFFFFFFE,  1'b0, 34};
    vecs[4]  = '{"u ffffffff/2",     32'hFFFFFFFF,  32'd2,         1'b0, 32'h7FFFFFFF,  32'd1,         1'b0, 34};
    vecs[5]  = '{"s ffffffff/2",     32'hFFFFFFFF,  32'd2,         1'b1, 32'd0,         32'hFFFFFFFF,  1'b0, 34};
    vecs[6]  = '{"s 7/0",            32'd7,         32'd0,         1'b1, 32'hFFFFFFFF,  32'd7,         1'b1, 2};
    vecs[7]  = '{"u 7/0",            32'd7,         32'd0,         1'b0, 32'hFFFFFFFF,  32'd7,         1'b1, 2};
    vecs[8]  = '{"s min/-1",         32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b1, 2};
    vecs[9]  = '{"u 80000000/ffffffff", 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000,  1'b0, 34};
    vecs[10] = '{"s min/2",          32'h80000000,  32'd2,         1'b1, 32'hC0000000,  32'd0,         1'b0, 34};
    vecs[11] = '{"u 100/7",          32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 34};
    vecs[12] = '{"u max/max",        32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'd1,         32'd0,         1'b0, 34};

    rst = 1'b1;
    div32 = 1'b0; s32 = 1'b0; a32 = '0; b32 = '0;
    div8 = 1'b0;  s8 = 1'b0;  a8 = '0;  b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result",    q32, 32'd0);
    check("reset remainder", r32, 32'd0);
    check("reset exception", {31'b0, e32}, 32'd0);
    check("reset ready",     {31'b0, rdy32}, 32'd0);
    check("reset busy",      {31'b0, busy32}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ready pulse width and result hold after completion.
    run32(32'd100, 32'd7, 1'b1, lat);
    check("pulse latency", lat, 32'd34);
    @(posedge clk); #1;
    check("pulse one cycle wide", {31'b0, rdy32}, 32'd0);
    check("result held", q32, 32'd14);

    // Table runs back-to-back: each start is issued in the previous DONE cycle.
    for (int i = 0; i < 13; i++) begin
      run32(vecs[i].a, vecs[i].b, vecs[i].sgn, lat);
      check({vecs[i].name, " q"},   q32, vecs[i].q);
      check({vecs[i].name, " r"},   r32, vecs[i].r);
      check({vecs[i].name, " exc"}, {31'b0, e32}, {31'b0, vecs[i].exc});
      check({vecs[i].name, " lat"}, lat, vecs[i].lat);
    end

    // Restart at iteration 10: only the new operation completes.
    @(negedge clk);
    a32 = 32'd1000; b32 = 32'd3; s32 = 1'b1; div32 = 1'b1;
    @(posedge clk); #1;
    div32 = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rdy32) pulses++;
    end
    run32(32'd9, 32'd3, 1'b1, lat);
    check("restart q",   q32, 32'd3);
    check("restart r",   r32, 32'd0);
    check("restart lat", lat, 32'd34);
    repeat (3) begin
      @(posedge clk); #1;
      if (rdy32) pulses++;
    end
    check("restart extra pulses", pulses, 32'd0);

    // Reset at iteration 10, with a simultaneous start that must be ignored.
    @(negedge clk);
    a32 = 32'd1000; b32 = 32'd3; s32 = 1'b1; div32 = 1'b1;
    @(posedge clk); #1;
    div32 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; div32 = 1'b1; a32 = 32'd5; b32 = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0; div32 = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rdy32) pulses++;
    end
    check("reset-mid pulses",    pulses, 32'd0);
    check("reset-mid result",    q32, 32'd0);
    check("reset-mid remainder", r32, 32'd0);
    check("reset-mid exception", {31'b0, e32}, 32'd0);
    check("reset-mid busy",      {31'b0, busy32}, 32'd0);

    // 8-bit instance.
    run8(8'h80, 8'd3, 1'b1, lat);
    check("w8 s -128/3 q",   {24'b0, q8}, 32'h000000D6);
    check("w8 s -128/3 r",   {24'b0, r8}, 32'h000000FE);
    check("w8 s -128/3 lat", lat, 32'd10);
    run8(8'h80, 8'hFF, 1'b1, lat);
    check("w8 s min/-1 q",   {24'b0, q8}, 32'h00000080);
    check("w8 s min/-1 exc", {31'b0, e8}, 32'd1);

    for (int i = 0; i < 48; i++) begin
      ra = 8'($urandom);
      rb = (i % 8 == 0) ? 8'h00 : 8'($urandom);
      rs = i[0];
      if (i == 5) begin ra = 8'h80; rb = 8'hFF; end
      model8(ra, rb, rs, eq, er, ee, elat);
      run8(ra, rb, rs, lat);
      check($sformatf("w8 rnd%0d %s %h/%h q", i, rs ? "s" : "u", ra, rb), {24'b0, q8}, {24'b0, eq});
      check($sformatf("w8 rnd%0d r", i), {24'b0, r8}, {24'b0, er});
      check($sformatf("w8 rnd%0d exc", i), {31'b0, e8}, {31'b0, ee});
      check($sformatf("w8 rnd%0d lat", i), lat, elat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
